// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST load/compute sequencer.
package mnist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    FLUSH,
    SWITCH,
    COMPUTE,
    DONE
  } state_e;

  localparam logic [1:0] SEL_L1 = 2'd0;
  localparam logic [1:0] SEL_L2 = 2'd1;
  localparam logic [1:0] SEL_L3 = 2'd2;
  localparam logic [1:0] SEL_L4 = 2'd3;

  localparam int unsigned W1_DEPTH_DEF = 802816;
  localparam int unsigned W2_DEPTH_DEF = 1048576;
  localparam int unsigned W3_DEPTH_DEF = 1048576;
  localparam int unsigned W4_DEPTH_DEF = 10240;
  localparam int unsigned X_DEPTH_DEF  = 784;

  typedef struct packed {
    logic in_ready;
    logic busy;
    logic done;
    logic en_compute;
    logic load_compute_ctrl;
  } ctrl_t;

  // Control outputs as seen while sitting in state s.
  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c.in_ready          = (s == LOAD_W) || (s == LOAD_X);
    c.busy              = (s != IDLE);
    c.done              = (s == DONE);
    c.en_compute        = (s == COMPUTE);
    c.load_compute_ctrl = !((s == SWITCH) || (s == COMPUTE));
    return c;
  endfunction

endpackage

// File: rtl/mnist_seg_counter.sv
// Segment address counter; wraps to 0 after the terminal address.
module mnist_seg_counter #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] count,
  output logic              tc_c
);

  assign tc_c = (count == last);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc)
      count <= tc_c ? '0 : count + ADDR_W'(1);
  end

endmodule

// File: rtl/mnist_load_seq.sv
// Streams weight and input bits into the MNIST banks, then hands off to compute.
module mnist_load_seq
  import mnist_pkg::*;
#(
  parameter int unsigned W_ADDR_LEN = 20,
  parameter int unsigned X_ADDR_LEN = 10,
  parameter int unsigned W1_DEPTH   = W1_DEPTH_DEF,
  parameter int unsigned W2_DEPTH   = W2_DEPTH_DEF,
  parameter int unsigned W3_DEPTH   = W3_DEPTH_DEF,
  parameter int unsigned W4_DEPTH   = W4_DEPTH_DEF,
  parameter int unsigned X_DEPTH    = X_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  start_x_only,
  input  logic                  in_valid,
  input  logic                  in_data,
  output logic                  in_ready,
  output logic                  w_wq_oc,
  output logic [W_ADDR_LEN-1:0] w_addr_oc,
  output logic [1:0]            w_sel_oc,
  output logic                  x_wq_oc,
  output logic [X_ADDR_LEN-1:0] x_addr_oc,
  output logic [1:0]            x_sel_oc,
  output logic                  wx_write_oc,
  output logic                  load_compute_ctrl,
  output logic                  en_compute,
  input  logic                  compute_finish,
  output logic                  busy,
  output logic                  done
);

  state_e                  state;
  state_e                  state_nxt;
  ctrl_t                   ctrl;
  logic [1:0]              sel;
  logic                    weights_loaded;
  logic                    go_full;
  logic                    go_x;
  logic                    acc_w;
  logic                    acc_x;
  logic                    w_clr;
  logic                    x_clr;
  logic                    w_tc_c;
  logic                    x_tc_c;
  logic [W_ADDR_LEN-1:0]   w_cnt;
  logic [W_ADDR_LEN-1:0]   w_last;
  logic [X_ADDR_LEN-1:0]   x_cnt;

  assign go_full = start || (start_x_only && !weights_loaded);
  assign go_x    = !start && start_x_only && weights_loaded;
  assign acc_w   = in_valid && in_ready && (state == LOAD_W);
  assign acc_x   = in_valid && in_ready && (state == LOAD_X);
  assign w_clr   = (state == IDLE) && go_full;
  assign x_clr   = (state == IDLE) && (go_full || go_x);

  always_comb begin
    w_last = W_ADDR_LEN'(W1_DEPTH - 1);
    case (sel)
      SEL_L2:  w_last = W_ADDR_LEN'(W2_DEPTH - 1);
      SEL_L3:  w_last = W_ADDR_LEN'(W3_DEPTH - 1);
      SEL_L4:  w_last = W_ADDR_LEN'(W4_DEPTH - 1);
      default: w_last = W_ADDR_LEN'(W1_DEPTH - 1);
    endcase
  end

  mnist_seg_counter #(.ADDR_W(W_ADDR_LEN)) u_w_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .inc   (acc_w),
    .last  (w_last),
    .count (w_cnt),
    .tc_c  (w_tc_c)
  );

  mnist_seg_counter #(.ADDR_W(X_ADDR_LEN)) u_x_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (x_clr),
    .inc   (acc_x),
    .last  (X_ADDR_LEN'(X_DEPTH - 1)),
    .count (x_cnt),
    .tc_c  (x_tc_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_full) state_nxt = LOAD_W;
               else if (go_x) state_nxt = LOAD_X;
      LOAD_W:  if (acc_w && w_tc_c && (sel == SEL_L4)) state_nxt = LOAD_X;
      LOAD_X:  if (acc_x && x_tc_c) state_nxt = FLUSH;
      FLUSH:   state_nxt = SWITCH;
      SWITCH:  state_nxt = COMPUTE;
      COMPUTE: if (compute_finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, control outputs and write strobes all launch from this register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ctrl           <= ctrl_of(IDLE);
      sel            <= SEL_L1;
      weights_loaded <= 1'b0;
      w_wq_oc        <= 1'b0;
      x_wq_oc        <= 1'b0;
      w_addr_oc      <= '0;
      w_sel_oc       <= 2'b00;
      x_addr_oc      <= '0;
      wx_write_oc    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctrl    <= ctrl_of(state_nxt);
      w_wq_oc <= acc_w;
      x_wq_oc <= acc_x;
      if (acc_w) begin
        w_addr_oc <= w_cnt;
        w_sel_oc  <= sel;
      end
      if (acc_x)
        x_addr_oc <= x_cnt;
      if (acc_w || acc_x)
        wx_write_oc <= in_data;
      if (w_clr)
        sel <= SEL_L1;
      else if (acc_w && w_tc_c)
        sel <= sel + 2'd1;
      if (acc_w && w_tc_c && (sel == SEL_L4))
        weights_loaded <= 1'b1;
    end
  end

  assign in_ready          = ctrl.in_ready;
  assign busy              = ctrl.busy;
  assign done              = ctrl.done;
  assign en_compute        = ctrl.en_compute;
  assign load_compute_ctrl = ctrl.load_compute_ctrl;
  assign x_sel_oc          = 2'b00;

endmodule

// File: tb/tb_mnist_load_seq.sv
// Directed/randomized bench for mnist_load_seq with small overridden depths.
module tb_mnist_load_seq;

  localparam int unsigned WA = 20;
  localparam int unsigned XA = 10;

  typedef struct packed {
    logic          is_w;
    logic [1:0]    sel;
    logic [WA-1:0] addr;
    logic          d;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          start_x_only = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_data = 1'b0;
  logic          compute_finish = 1'b0;
  logic          in_ready;
  logic          w_wq_oc;
  logic [WA-1:0] w_addr_oc;
  logic [1:0]    w_sel_oc;
  logic          x_wq_oc;
  logic [XA-1:0] x_addr_oc;
  logic [1:0]    x_sel_oc;
  logic          wx_write_oc;
  logic          load_compute_ctrl;
  logic          en_compute;
  logic          busy;
  logic          done;

  int   checks = 0;
  int   errors = 0;
  int   dep [4] = '{4, 4, 4, 2};
  rec_t obs_q [$];
  rec_t exp_q [$];
  logic bits_q [$];
  logic mon_en = 1'b0;
  logic acc_prev = 1'b0;

  mnist_load_seq #(
    .W_ADDR_LEN (WA),
    .X_ADDR_LEN (XA),
    .W1_DEPTH   (4),
    .W2_DEPTH   (4),
    .W3_DEPTH   (4),
    .W4_DEPTH   (2),
    .X_DEPTH    (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .start_x_only      (start_x_only),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .w_wq_oc           (w_wq_oc),
    .w_addr_oc         (w_addr_oc),
    .w_sel_oc          (w_sel_oc),
    .x_wq_oc           (x_wq_oc),
    .x_addr_oc         (x_addr_oc),
    .x_sel_oc          (x_sel_oc),
    .wx_write_oc       (wx_write_oc),
    .load_compute_ctrl (load_compute_ctrl),
    .en_compute        (en_compute),
    .compute_finish    (compute_finish),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A strobe must appear exactly in the cycle after each accepted beat.
  always @(posedge clk) acc_prev <= in_valid && in_ready && !rst;

  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_follows_beat", 32'(w_wq_oc | x_wq_oc), 32'(acc_prev));
      check("single_strobe", 32'(w_wq_oc & x_wq_oc), 32'd0);
      if (w_wq_oc) obs_q.push_back(rec_t'({1'b1, w_sel_oc, w_addr_oc, wx_write_oc}));
      if (x_wq_oc) obs_q.push_back(rec_t'({1'b0, x_sel_oc, WA'(x_addr_oc), wx_write_oc}));
    end
  end

  // Reference: walk accepted bits through the weight banks, then the input bank.
  function automatic void build_exp(input bit full);
    int sel  = 0;
    int addr = 0;
    bit w    = full;
    foreach (bits_q[i]) begin
      if (w) begin
        exp_q.push_back(rec_t'({1'b1, 2'(sel), WA'(addr), bits_q[i]}));
        addr++;
        if (addr == dep[sel]) begin
          addr = 0;
          sel++;
          if (sel == 4) w = 1'b0;
        end
      end else begin
        exp_q.push_back(rec_t'({1'b0, 2'b00, WA'(addr), bits_q[i]}));
        addr++;
      end
    end
  endfunction

  task automatic compare_q(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
    bits_q.delete();
  endtask

  // mode 0: continuous valid, 1: toggling 1,0,1,0, other: random gaps.
  task automatic feed(input int n, input int mode);
    int   got = 0;
    int   cyc = 0;
    logic v;
    logic d;
    while (got < n && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      d = 1'($urandom);
      in_valid = v;
      in_data  = d;
      if (v && in_ready) begin
        bits_q.push_back(d);
        got++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("feed_accepted", 32'(got), 32'(n));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_strobes"}, 32'({in_ready, w_wq_oc, x_wq_oc, wx_write_oc}), 32'd0);
    check({tag, "_w_addr"}, 32'(w_addr_oc), 32'd0);
    check({tag, "_x_addr"}, 32'(x_addr_oc), 32'd0);
    check({tag, "_sels"}, 32'({w_sel_oc, x_sel_oc}), 32'd0);
    check({tag, "_ctrl"}, 32'({load_compute_ctrl, en_compute, busy, done}), 32'b1000);
  endtask

  // Finish a run from the FLUSH cycle through DONE back to IDLE.
  task automatic finish_run(input string tag);
    check({tag, "_flush"}, 32'({in_ready, busy, load_compute_ctrl, en_compute}), 32'b0110);
    in_valid = 1'b1;
    in_data  = 1'($urandom);
    step();
    check({tag, "_switch"}, 32'({in_ready, busy, load_compute_ctrl, en_compute, done}), 32'b01000);
    compute_finish = 1'b1;
    step();
    check({tag, "_compute"}, 32'({in_ready, busy, load_compute_ctrl, en_compute, done}), 32'b01010);
    step();
    check({tag, "_done"}, 32'({in_ready, busy, load_compute_ctrl, en_compute, done}), 32'b01101);
    compute_finish = 1'b0;
    in_valid = 1'b0;
    step();
    check({tag, "_idle"}, 32'({in_ready, busy, load_compute_ctrl, en_compute, done}), 32'b00100);
  endtask

  initial begin
    step(); step(); step();
    check_reset("rst_init");
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    check_reset("idle_after_rst");

    // Run 1: start and start_x_only together, continuous stream.
    start = 1'b1;
    start_x_only = 1'b1;
    step();
    start = 1'b0;
    start_x_only = 1'b0;
    check("run1_entry", 32'({in_ready, busy, load_compute_ctrl}), 32'b111);
    feed(17, 0);
    check("run1_last_x", 32'({x_wq_oc, x_addr_oc}), 32'({1'b1, 10'd2}));
    finish_run("run1");
    build_exp(1'b1);
    compare_q("run1");

    // Run 2: input-only reload with random gaps; start during COMPUTE ignored.
    start_x_only = 1'b1;
    step();
    start_x_only = 1'b0;
    check("run2_entry", 32'({in_ready, busy}), 32'b11);
    feed(3, 2);
    check("run2_flush", 32'({in_ready, busy, en_compute}), 32'b010);
    step();
    step();
    check("run2_compute", 32'({in_ready, busy, load_compute_ctrl, en_compute, done}), 32'b01010);
    start = 1'b1;
    step();
    start = 1'b0;
    check("run2_start_ignored", 32'({in_ready, busy, load_compute_ctrl, en_compute, done}), 32'b01010);
    step();
    check("run2_still_compute", 32'({busy, en_compute, done}), 32'b110);
    compute_finish = 1'b1;
    step();
    check("run2_done", 32'({busy, load_compute_ctrl, en_compute, done}), 32'b1101);
    compute_finish = 1'b0;
    step();
    check("run2_idle", 32'({busy, done}), 32'b00);
    build_exp(1'b0);
    compare_q("run2");

    // Run 3: abort by reset with the counter at bank 2, address 1.
    start = 1'b1;
    step();
    start = 1'b0;
    feed(9, 2);
    check("run3_last_w", 32'({w_wq_oc, w_sel_oc, w_addr_oc}), 32'({1'b1, 2'd2, 20'd0}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("rst_mid");
    step();
    check_reset("rst_idle");
    build_exp(1'b1);
    compare_q("run3");

    // Run 4: start_x_only after reset must reload weights; toggling valid.
    start_x_only = 1'b1;
    step();
    start_x_only = 1'b0;
    check("run4_entry", 32'({in_ready, busy}), 32'b11);
    feed(17, 1);
    check("run4_last_x", 32'({x_wq_oc, x_addr_oc}), 32'({1'b1, 10'd2}));
    finish_run("run4");
    build_exp(1'b1);
    compare_q("run4");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mnist_load_seq.md
MNIST_LOAD_SEQ -- requirements
Module: mnist_load_seq

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- W_ADDR_LEN, 20, weight address width
- X_ADDR_LEN, 10, input address width
- W1_DEPTH, 802816, layer-1 weight bits
- W2_DEPTH, 1048576, layer-2 weight bits
- W3_DEPTH, 1048576, layer-3 weight bits
- W4_DEPTH, 10240, layer-4 weight bits
- X_DEPTH, 784, input bits
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: load all weights, then input, then compute
- start_x_only  in  1  pulse: load input only, then compute
- in_valid  in  1  stream bit valid
- in_data  in  1  stream bit
- in_ready  out  1  sequencer accepts a bit this cycle
- w_wq_oc  out  1  weight write strobe
- w_addr_oc  out  W_ADDR_LEN  weight address
- w_sel_oc  out  2  weight bank 0..3
- x_wq_oc  out  1  input write strobe
- x_addr_oc  out  X_ADDR_LEN  input address
- x_sel_oc  out  2  input bank, always 0
- wx_write_oc  out  1  write data bit
- load_compute_ctrl  out  1  1 = load mode, 0 = compute mode
- en_compute  out  1  compute enable to mnist_nn
- compute_finish  in  1  compute complete from mnist_nn
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of compute

Function
REQ-003 FSM states SHALL be IDLE, LOAD_W, LOAD_X, FLUSH, SWITCH, COMPUTE, DONE.
REQ-004 IDLE transitions SHALL be: start -> LOAD_W with sel=0, addr=0; start_x_only with weights_loaded=1 -> LOAD_X; start_x_only with weights_loaded=0 -> treated as start; both asserted -> start wins.
REQ-005 in_ready SHALL be 1 only in LOAD_W and LOAD_X; a beat is accepted when in_valid && in_ready; in_valid in any other state SHALL be ignored.
REQ-006 Each accepted beat SHALL produce exactly one write strobe (w_wq_oc or x_wq_oc) in the next cycle, with the beat's address and wx_write_oc=in_data; strobes SHALL be low otherwise.
REQ-007 Throughput SHALL be one bit per cycle; in_valid gaps SHALL stall the address counter with no strobe.
REQ-008 In LOAD_W, the accepted beat at addr = depth(sel)-1 SHALL reset addr to 0 and increment sel; the accepted beat at sel=3, addr=W4_DEPTH-1 SHALL set weights_loaded=1 and enter LOAD_X with x addr=0.
REQ-009 In LOAD_X, the accepted beat at addr=X_DEPTH-1 SHALL enter FLUSH; its strobe SHALL issue in FLUSH.
REQ-010 FLUSH -> SWITCH SHALL take 1 cycle; in SWITCH load_compute_ctrl=0 and en_compute=0; SWITCH -> COMPUTE SHALL take 1 cycle.
REQ-011 In COMPUTE, en_compute=1 and load_compute_ctrl=0; compute_finish=1 SHALL move to DONE; compute_finish outside COMPUTE SHALL be ignored.
REQ-012 In DONE, done=1, en_compute=0, load_compute_ctrl=1, for exactly 1 cycle, then IDLE.
REQ-013 Addresses SHALL hold their last value when no strobe is issued; there SHALL be no wrap beyond depth-1 within a segment.
REQ-014 start/start_x_only while busy=1 SHALL be ignored.

Reset
REQ-015 rst SHALL force IDLE with in_ready=0, w_wq_oc=0, x_wq_oc=0, w_addr_oc=0, x_addr_oc=0, w_sel_oc=0, x_sel_oc=0, wx_write_oc=0, load_compute_ctrl=1, en_compute=0, busy=0, done=0, weights_loaded=0.
REQ-016 rst mid-operation SHALL abort with no further strobes; a partially written bank is not scrubbed.

Structure
REQ-017 The state enum, the bank select encodings 0..3, and the default depth constants SHALL live in shared package mnist_pkg.
REQ-018 The address counter with terminal-count flag SHALL be sub-module mnist_seg_counter, instantiated once for weights and once for input.

Verification (depths overridden to W1=4, W2=4, W3=4, W4=2, X=3)
REQ-019 Stimulus: start, then 17 continuous bits -> required: 14 w strobes with sel/addr pairs 0/0..0/3, 1/0..1/3, 2/0..2/3, 3/0..3/1; then 3 x strobes at addr 0..2; FLUSH→SWITCH→COMPUTE; en_compute=1 two cycles after the last x strobe.
REQ-020 Stimulus: in_valid toggling 1,0,1,0 during LOAD_W -> required: strobes only in cycles following accepted beats; addr advances by one per strobe.
REQ-021 Stimulus: compute_finish held 1 from SWITCH -> required: ignored in SWITCH; DONE entered on the first COMPUTE cycle; done pulses once; load_compute_ctrl=1.
REQ-022 Stimulus: after a full run, start_x_only plus 3 bits -> required: no w strobes, x addr 0..2, compute then done; start_x_only after rst -> full weight load.
REQ-023 Stimulus: rst at sel=2, addr=1 -> required: all outputs at reset values the next cycle; subsequent start restarts at sel=0, addr=0.
REQ-024 Stimulus: start asserted during COMPUTE -> required: ignored, state unchanged.
